// File: rtl/man_seq_pkg.sv
// rtl/man_seq_pkg.sv - shared widths, weight count and FSM encoding for the MAN array sequencer
package man_seq_pkg;

    localparam int ADDR_W_DEF    = 20;
    localparam int DATA_W_DEF    = 24;
    localparam int N_MAN_DEF     = 8;
    localparam int W_PER_MAN_DEF = 8;
    localparam int PIPE_LAT_DEF  = 3;
    localparam int N_WEIGHTS     = N_MAN_DEF * W_PER_MAN_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/man_seq_delay.sv
// rtl/man_seq_delay.sv - PIPE_LAT-deep valid shift register aligning x_valid with the MAN result
module man_seq_delay #(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic out_valid,
    output logic empty
);

    logic [PIPE_LAT-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr[0] <= in_valid;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out_valid = sr[PIPE_LAT-1];
    assign empty     = (sr == '0);

endmodule

// File: rtl/man_array_sequencer.sv
// rtl/man_array_sequencer.sv - start/done sequencer: weight load, input stream and aligned result write
module man_array_sequencer
    import man_seq_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_MAN     = N_MAN_DEF,
    parameter int W_PER_MAN = W_PER_MAN_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_W-1:0]            w_base,
    input  logic [ADDR_W-1:0]            x_base,
    input  logic [ADDR_W-1:0]            y_base,
    input  logic [ADDR_W-1:0]            n_data,
    output logic                         busy,
    output logic                         done,
    output logic                         RAM1_OE,
    output logic [ADDR_W-1:0]            RAM1_A,
    input  logic [DATA_W-1:0]            RAM1_Q,
    output logic [DATA_W-1:0]            RAM1_Q_latch,
    output logic [N_MAN-1:0]             wen,
    output logic [$clog2(W_PER_MAN)-1:0] MAN_A_WEIGHT,
    output logic                         x_valid,
    output logic                         RAM2_WE,
    output logic [ADDR_W-1:0]            RAM2_A
);

    localparam int NW = N_MAN * W_PER_MAN;
    localparam int KW = $clog2(NW);
    localparam int SW = $clog2(W_PER_MAN);

    seq_state_t        state, state_n;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] w_b, x_b, y_b, n_r;
    logic [ADDR_W-1:0] wr_j;
    logic [KW-1:0]     wen_k;
    logic [KW-1:0]     wen_man;
    logic              wen_v;
    logic              xv;
    logic              cnt_clr, cnt_inc, accept, flush;
    logic              dl_out, dl_empty;

    assign flush = abort && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            LOAD: begin
                if (cnt == ADDR_W'(NW - 1)) begin
                    state_n = (n_r != '0) ? STREAM : DRAIN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            STREAM: begin
                if (cnt == n_r - ADDR_W'(1)) begin
                    state_n = DRAIN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            // Wait for the last weight strobe and every in-flight result to leave.
            DRAIN: begin
                if (dl_empty && !xv && !wen_v) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (flush) begin
            state_n = IDLE;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            w_b   <= '0;
            x_b   <= '0;
            y_b   <= '0;
            n_r   <= '0;
            wen_v <= 1'b0;
            wen_k <= '0;
            xv    <= 1'b0;
            wr_j  <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + ADDR_W'(1);
            end
            if (accept) begin
                w_b <= w_base;
                x_b <= x_base;
                y_b <= y_base;
                n_r <= n_data;
            end
            // Weight strobe and stream valid trail the RAM1 issue by the read latency.
            wen_v <= (state == LOAD) && !abort;
            wen_k <= cnt[KW-1:0];
            xv    <= (state == STREAM) && !abort;
            if (accept || flush) begin
                wr_j <= '0;
            end else if (dl_out) begin
                wr_j <= wr_j + ADDR_W'(1);
            end
        end
    end

    man_seq_delay #(
        .PIPE_LAT (PIPE_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (xv),
        .out_valid (dl_out),
        .empty     (dl_empty)
    );

    always_comb begin
        RAM1_OE = 1'b0;
        RAM1_A  = '0;
        case (state)
            LOAD: begin
                RAM1_OE = 1'b1;
                RAM1_A  = w_b + cnt;
            end
            STREAM: begin
                RAM1_OE = 1'b1;
                RAM1_A  = x_b + cnt;
            end
            default: begin
            end
        endcase
    end

    assign wen_man = wen_k / KW'(W_PER_MAN);

    always_comb begin
        wen = '0;
        for (int m = 0; m < N_MAN; m++) begin
            wen[m] = wen_v && (wen_man == KW'(m));
        end
    end

    assign MAN_A_WEIGHT = wen_v ? SW'(wen_k % KW'(W_PER_MAN)) : '0;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign x_valid      = xv;
    assign RAM2_WE      = dl_out;
    assign RAM2_A       = dl_out ? (y_b + wr_j) : '0;
    assign RAM1_Q_latch = RAM1_Q;

endmodule

// File: tb/tb_man_array_sequencer.sv
// tb/tb_man_array_sequencer.sv - scoreboard bench over three sequencers with PIPE_LAT 1, 3 and 7
module tb_man_array_sequencer;
    import man_seq_pkg::*;

    localparam int AW = 20;
    localparam int DW = 24;
    localparam int LATS [3] = '{1, 3, 7};

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] w_base, x_base, y_base, n_data;
    logic [DW-1:0] ram1_q = '0;

    logic [2:0]    busy, done, oe, xv, we2;
    logic [AW-1:0] a1 [3];
    logic [AW-1:0] a2 [3];
    logic [DW-1:0] ql [3];
    logic [7:0]    wen [3];
    logic [2:0]    sl [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] q_ram1 [$];
    logic [AW-1:0] q_ram2 [$];
    logic [10:0]   q_wen [$];

    int   nwr [3];
    int   ndone [3];
    int   done_cyc [3];
    int   load0 [3];
    int   nwen, nxv, stream0, first_wr, oe_in_job;
    bit   seen_wr;
    logic [2:0] busy_prev = '0;

    int   s_wr [3];
    int   s_done [3];
    int   s_wen, s_xv;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        man_array_sequencer #(
            .PIPE_LAT (LATS[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .abort        (abort),
            .w_base       (w_base),
            .x_base       (x_base),
            .y_base       (y_base),
            .n_data       (n_data),
            .busy         (busy[g]),
            .done         (done[g]),
            .RAM1_OE      (oe[g]),
            .RAM1_A       (a1[g]),
            .RAM1_Q       (ram1_q),
            .RAM1_Q_latch (ql[g]),
            .wen          (wen[g]),
            .MAN_A_WEIGHT (sl[g]),
            .x_valid      (xv[g]),
            .RAM2_WE      (we2[g]),
            .RAM2_A       (a2[g])
        );
    end

    always @(posedge clk) ram1_q <= {4'h5, a1[1]} ^ 24'h3C3C3C;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            if (busy[g] && !busy_prev[g]) load0[g] = cyc;
            if (we2[g]) nwr[g]++;
            if (done[g]) begin
                ndone[g]++;
                done_cyc[g] = cyc;
            end
        end
        if (busy[1] && !busy_prev[1]) begin
            oe_in_job = 0;
            seen_wr   = 1'b0;
        end
        busy_prev = busy;
        if (oe[1]) begin
            if (oe_in_job == N_WEIGHTS) stream0 = cyc;
            oe_in_job++;
            check("ram1_avail", 32'(q_ram1.size() != 0), 1);
            if (q_ram1.size() != 0) check("ram1_a", 32'(a1[1]), 32'(q_ram1.pop_front()));
        end else begin
            check("ram1_a_idle", 32'(a1[1]), 0);
        end
        if (wen[1] != 8'd0) begin
            nwen++;
            check("wen_avail", 32'(q_wen.size() != 0), 1);
            if (q_wen.size() != 0) check("wen_slot", 32'({wen[1], sl[1]}), 32'(q_wen.pop_front()));
        end
        if (xv[1]) begin
            nxv++;
            check("q_latch", 32'(ql[1]), 32'(ram1_q));
        end
        if (we2[1]) begin
            if (!seen_wr) begin
                first_wr = cyc;
                seen_wr  = 1'b1;
            end
            check("ram2_avail", 32'(q_ram2.size() != 0), 1);
            if (q_ram2.size() != 0) check("ram2_a", 32'(a2[1]), 32'(q_ram2.pop_front()));
        end else begin
            check("ram2_a_idle", 32'(a2[1]), 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        for (int g = 0; g < 3; g++) begin
            s_wr[g]   = nwr[g];
            s_done[g] = ndone[g];
        end
        s_wen = nwen;
        s_xv  = nxv;
    endtask

    task automatic push_expect(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] y,
                               input int nw, input int nx, input int nwr_e);
        logic [AW-1:0] a;
        logic [7:0]    oh;
        for (int k = 0; k < nw; k++) begin
            a  = w + AW'(k);
            oh = 8'd1 << (k / W_PER_MAN_DEF);
            q_ram1.push_back(a);
            q_wen.push_back({oh, 3'(k % W_PER_MAN_DEF)});
        end
        for (int i = 0; i < nx; i++) begin
            a = x + AW'(i);
            q_ram1.push_back(a);
        end
        for (int i = 0; i < nwr_e; i++) begin
            a = y + AW'(i);
            q_ram2.push_back(a);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] y,
                            input logic [AW-1:0] n);
        w_base = w;
        x_base = x;
        y_base = y;
        n_data = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (busy != 3'b000 && k < 20000) begin
            tick();
            k++;
        end
        check("job_timeout", 32'(k < 20000), 1);
    endtask

    task automatic finish_job(input int n);
        wait_idle();
        for (int g = 0; g < 3; g++) begin
            check("done_cnt", ndone[g] - s_done[g], 1);
            check("wr_cnt", nwr[g] - s_wr[g], n);
            check("done_lat", done_cyc[g] - load0[g], (n == 0) ? 66 : 66 + n + LATS[g]);
        end
        check("wen_cnt", nwen - s_wen, N_WEIGHTS);
        check("xv_cnt", nxv - s_xv, n);
        if (n > 0) check("first_wr_lat", first_wr - stream0, 4);
        check("q_left", q_ram1.size() + q_ram2.size() + q_wen.size(), 0);
    endtask

    task automatic run_job(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] y,
                           input logic [AW-1:0] n);
        snap();
        push_expect(w, x, y, N_WEIGHTS, int'(n), int'(n));
        do_start(w, x, y, n);
        finish_job(int'(n));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        w_base = '0;
        x_base = '0;
        y_base = '0;
        n_data = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_oe", 32'(oe), 0);
        check("rst_xv", 32'(xv), 0);
        check("rst_we2", 32'(we2), 0);
        check("rst_a1", 32'(a1[1]), 0);
        check("rst_a2", 32'(a2[1]), 0);
        check("rst_wen", 32'(wen[1]), 0);
        rst = 1'b0;
        tick();

        run_job(20'd0, 20'd64, 20'd0, 20'd4096);
        run_job(20'd0, 20'd64, 20'd0, 20'd0);
        run_job(20'd0, 20'hFFFFE, 20'hFFFFF, 20'd4);

        // abort at stream index 100
        snap();
        push_expect(20'd0, 20'd5000, 20'd7000, N_WEIGHTS, 101, 97);
        do_start(20'd0, 20'd5000, 20'd7000, 20'd300);
        repeat (N_WEIGHTS + 100) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_oe", 32'(oe), 0);
        check("ab_xv", 32'(xv), 0);
        check("ab_we2", 32'(we2), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_wen", 32'(wen[1]), 0);
        repeat (20) tick();
        for (int g = 0; g < 3; g++) check("ab_no_done", ndone[g] - s_done[g], 0);
        check("ab_xv_cnt", nxv - s_xv, 100);
        check("ab_wr_cnt", nwr[1] - s_wr[1], 97);
        check("ab_q_left", q_ram1.size() + q_ram2.size() + q_wen.size(), 0);
        run_job(20'd0, 20'd64, 20'd0, 20'd200);

        // start while busy is ignored
        snap();
        push_expect(20'd100, 20'd1000, 20'd500, N_WEIGHTS, 8, 8);
        do_start(20'd100, 20'd1000, 20'd500, 20'd8);
        repeat (10) tick();
        w_base = 20'd7;
        x_base = 20'd9;
        y_base = 20'd11;
        n_data = 20'd3;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        finish_job(8);

        // reset in the middle of LOAD
        push_expect(20'd0, 20'd64, 20'd0, N_WEIGHTS, 10, 10);
        do_start(20'd0, 20'd64, 20'd0, 20'd10);
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_oe", 32'(oe), 0);
        check("mrst_a1", 32'(a1[1]), 0);
        check("mrst_wen", 32'(wen[1]), 0);
        check("mrst_slot", 32'(sl[1]), 0);
        q_ram1.delete();
        q_ram2.delete();
        q_wen.delete();
        tick();
        rst = 1'b0;
        tick();
        run_job(20'd300, 20'd20, 20'd40, 20'd37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
